// File: rtl/bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bridge_pkg: shared types/constants for the AHB-to-APB sequencer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  localparam int c_idx_msb = 15;
  localparam int c_idx_lsb = 12;

  function automatic logic is_xfer(input logic [1:0] htrans);
    return (htrans == c_htrans_nonseq) || (htrans == c_htrans_seq);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_wait_timer: ACCESS-phase wait counter, flags TIMEOUT-1 reached  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = 8'd0;
    end else if (i_inc) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/apb_xfer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_xfer_ctrl: sequences one AHB transfer onto APB SETUP/ACCESS     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_xfer_ctrl
  import bridge_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [ADDR_W-1:0]     HADDR,
  input  logic [DATA_W-1:0]     HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_W-1:0]     HRDATA,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [NUM_SLAVES-1:0] PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PSLVERR
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [3:0]            idx_q, idx_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [DATA_W-1:0]     hrdata_q, hrdata_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;

  logic       w_accept;
  logic [3:0] w_idx;
  logic       w_mapped;
  logic       w_tmr_clr;
  logic       w_tmr_inc;
  logic       w_tmr_expired;

  assign w_accept = HSEL & is_xfer(HTRANS) & HREADY;
  assign w_idx    = HADDR[c_idx_msb:c_idx_lsb];
  assign w_mapped = (32'(w_idx) < NUM_SLAVES);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (HCLK),
    .rst       (HRESET),
    .i_clr     (w_tmr_clr),
    .i_inc     (w_tmr_inc),
    .o_expired (w_tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    idx_d     = idx_q;
    hrdata_d  = hrdata_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    w_tmr_clr = 1'b0;
    w_tmr_inc = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (w_accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          idx_d   = w_idx;
          state_d = w_mapped ? ST_LATCH : ST_ERR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        // HWDATA is only valid now, one cycle after the address phase
        if (write_q) begin
          pwdata_d = HWDATA;
        end
        paddr_d  = addr_q;
        pwrite_d = write_q;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          psel_d[i] = (idx_q == 4'(i));
        end
        w_tmr_clr = 1'b1;
        state_d   = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY takes priority over an expiring timer
        if (PREADY) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!write_q) begin
              hrdata_d = PRDATA;
            end
          end
        end else if (w_tmr_expired) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_ERR1;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // AHB response flops are a pure function of the state being entered
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      idx_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_xfer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_xfer_ctrl: directed scoreboard bench for apb_xfer_ctrl       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_apb_xfer_ctrl;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          t_done;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  psel;
    logic        write;
    logic [31:0] wdata;
  } apb_t;

  logic        HCLK, HRESET, HSEL, HSEL2, HWRITE, HREADY;
  logic [1:0]  HTRANS;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  wire         HREADYOUT, HRESP, PENABLE, PWRITE;
  wire  [31:0] HRDATA, PWDATA;
  wire  [15:0] PADDR;
  wire  [3:0]  PSELx;

  wire         d2_hreadyout, d2_hresp, d2_penable, d2_pwrite;
  wire  [31:0] d2_hrdata, d2_pwdata;
  wire  [15:0] d2_paddr;
  wire  [1:0]  d2_psel;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  rsp_t rsp_q[$];
  apb_t apb_q[$];

  int          slv_wait  = 0;
  bit          slv_stuck = 0;
  int          acc_cnt   = 0;
  int          last_acc  = 0;
  logic [31:0] model_hrdata = 32'h0;

  apb_xfer_ctrl #(.NUM_SLAVES(4), .TIMEOUT(16), .ADDR_W(16), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  apb_xfer_ctrl #(.NUM_SLAVES(2), .TIMEOUT(16), .ADDR_W(16), .DATA_W(32)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL2), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(d2_hreadyout),
    .HRESP(d2_hresp), .HRDATA(d2_hrdata), .PADDR(d2_paddr), .PSELx(d2_psel),
    .PENABLE(d2_penable), .PWRITE(d2_pwrite), .PWDATA(d2_pwdata), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // APB slave: PREADY rises on ACCESS cycle slv_wait+1 unless stuck
  initial forever begin
    @(negedge HCLK);
    if (PSELx != 4'b0 && PENABLE) begin
      acc_cnt++;
      last_acc = acc_cnt;
      PREADY   = !slv_stuck && (acc_cnt > slv_wait);
    end else begin
      if (PSELx != 4'b0) last_acc = 0;
      acc_cnt = 0;
      PREADY  = 1'b0;
    end
  end

  // AHB response monitor: a response completes when HREADYOUT rises
  initial begin
    logic prev_rdy;
    logic prev_rsp;
    rsp_t e;
    prev_rdy = 1'b1;
    prev_rsp = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        prev_rdy = 1'b1;
        prev_rsp = 1'b0;
      end else begin
        if (HREADYOUT && !prev_rdy) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_response", 32'(rsp_q.size()), 32'd1);
          end else begin
            e = rsp_q.pop_front();
            chk("hresp", 32'(HRESP), 32'(e.resp));
            chk("hresp_first_cycle", 32'(prev_rsp), 32'(e.resp));
            chk("hrdata", HRDATA, e.rdata);
            chk("latency", 32'(cyc), 32'(e.t_done));
            chk("access_cycles", 32'(last_acc), 32'(e.acc));
          end
        end
        prev_rdy = HREADYOUT;
        prev_rsp = HRESP;
      end
    end
  end

  // APB monitor: checks address/select/data during each SETUP phase
  initial begin
    apb_t a;
    forever begin
      @(negedge HCLK);
      if (!HRESET && PSELx != 4'b0 && !PENABLE) begin
        if (apb_q.size() == 0) begin
          chk("unexpected_setup", 32'(PSELx), 32'd0);
        end else begin
          a = apb_q.pop_front();
          chk("paddr", 32'(PADDR), 32'(a.addr));
          chk("psel", 32'(PSELx), 32'(a.psel));
          chk("pwrite", 32'(PWRITE), 32'(a.write));
          if (a.write) chk("pwdata", PWDATA, a.wdata);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after the address phase
  task automatic xfer(input logic [15:0] addr, input logic write, input logic [31:0] wdata,
                      input logic [3:0] psel, input logic [31:0] slv_rdata, input logic resp,
                      input int lat, input int acc, input bit owe_rsp);
    rsp_t r;
    apb_t a;
    if (psel != 4'b0) begin
      a.addr = addr; a.psel = psel; a.write = write; a.wdata = wdata;
      apb_q.push_back(a);
    end
    if (!write && !resp) model_hrdata = slv_rdata;
    if (owe_rsp) begin
      r.resp = resp; r.rdata = model_hrdata; r.t_done = cyc + lat; r.acc = acc;
      rsp_q.push_back(r);
    end
    PRDATA = slv_rdata;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = write;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0) && n < 100) begin
      @(posedge HCLK);
      n++;
    end
    if (n >= 100) chk("drain_budget", 32'(rsp_q.size() + apb_q.size()), 32'd0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    HRESET = 1'b1; HSEL = 1'b0; HSEL2 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 16'h0; HWDATA = 32'h0; HREADY = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    #12;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_psel", 32'(PSELx), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // zero-wait write
    slv_wait = 0; slv_stuck = 0; PSLVERR = 1'b0;
    xfer(16'h1004, 1'b1, 32'hDEADBEEF, 4'b0010, 32'h0, 1'b0, 4, 1, 1'b1);
    @(negedge HCLK);
    chk("w0_t1_hreadyout", 32'(HREADYOUT), 32'd0);
    @(negedge HCLK);
    chk("w0_t2_psel", 32'(PSELx), 32'h2);
    chk("w0_t2_paddr", 32'(PADDR), 32'h1004);
    chk("w0_t2_penable", 32'(PENABLE), 32'd0);
    @(negedge HCLK);
    chk("w0_t3_penable", 32'(PENABLE), 32'd1);
    chk("w0_t3_pwdata", PWDATA, 32'hDEADBEEF);
    wait_drain();

    // read with 3 wait states
    slv_wait = 3;
    xfer(16'h3010, 1'b0, 32'h0, 4'b1000, 32'h12345678, 1'b0, 7, 4, 1'b1);
    wait_drain();
    chk("hold_paddr", 32'(PADDR), 32'h3010);

    // PSLVERR write, then read accepted during ERR2
    slv_wait = 0; PSLVERR = 1'b1;
    xfer(16'h1100, 1'b1, 32'hCAFEF00D, 4'b0010, 32'h0, 1'b1, 5, 1, 1'b1);
    n = 0;
    while (!(HRESP && !HREADYOUT) && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    chk("err1_seen", 32'(HRESP && !HREADYOUT), 32'd1);
    @(posedge HCLK); #1;
    PSLVERR = 1'b0;
    xfer(16'h2020, 1'b0, 32'h0, 4'b0100, 32'hA5A50001, 1'b0, 4, 1, 1'b1);
    @(negedge HCLK);
    chk("b2b_latch_hreadyout", 32'(HREADYOUT), 32'd0);
    chk("b2b_latch_hresp", 32'(HRESP), 32'd0);
    wait_drain();

    // timeout: PREADY never rises
    slv_stuck = 1;
    xfer(16'h3008, 1'b1, 32'h0BADF00D, 4'b1000, 32'h0, 1'b1, 20, 16, 1'b1);
    wait_drain();
    slv_stuck = 0;

    // unmapped access on the two-slave instance
    HSEL2 = 1'b1; HTRANS = 2'b10; HADDR = 16'h2000; HWRITE = 1'b0;
    @(negedge HCLK);
    chk("unm_t0_psel", 32'(d2_psel), 32'd0);
    @(posedge HCLK); #1;
    HSEL2 = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    chk("unm_t1_hreadyout", 32'(d2_hreadyout), 32'd0);
    chk("unm_t1_hresp", 32'(d2_hresp), 32'd1);
    chk("unm_t1_psel", 32'(d2_psel), 32'd0);
    @(negedge HCLK);
    chk("unm_t2_hreadyout", 32'(d2_hreadyout), 32'd1);
    chk("unm_t2_hresp", 32'(d2_hresp), 32'd1);
    chk("unm_t2_psel", 32'(d2_psel), 32'd0);
    @(negedge HCLK);
    chk("unm_t3_hresp", 32'(d2_hresp), 32'd0);
    @(posedge HCLK); #1;

    // reset in the middle of ACCESS
    slv_stuck = 1;
    xfer(16'h0040, 1'b1, 32'h11112222, 4'b0001, 32'h0, 1'b0, 0, 0, 1'b0);
    n = 0;
    while (!PENABLE && n < 10) begin
      @(negedge HCLK);
      n++;
    end
    chk("rst_mid_access_reached", 32'(PENABLE), 32'd1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(PSELx), 32'd0);
    chk("rst_mid_penable", 32'(PENABLE), 32'd0);
    chk("rst_mid_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_mid_hresp", 32'(HRESP), 32'd0);
    chk("rst_mid_hrdata", HRDATA, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    slv_stuck = 0;
    repeat (3) @(negedge HCLK);
    chk("post_rst_psel", 32'(PSELx), 32'd0);
    chk("post_rst_hreadyout", 32'(HREADYOUT), 32'd1);

    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    chk("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
